// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO write/read controls: Gray conversion and the full-pointer compare.
package fifo_pkg;

  localparam int ADDRSIZE_DEF = 4;
  localparam int PTR_MAX      = 32;

  typedef logic [PTR_MAX-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Bits at or above w are ignored, so callers may pass zero- or garbage-extended values.
  function automatic ptr_t gray2bin(input ptr_t g, input int w);
    ptr_t m;
    ptr_t b;
    m = (ptr_t'(1) << w) - ptr_t'(1);
    b = '0;
    for (int i = 0; i < PTR_MAX; i++) b[i] = ^((g & m) >> i);
    return b;
  endfunction

  // Read pointer as it would look if the writer were exactly one lap ahead (top two bits inverted).
  function automatic ptr_t full_ptr(input ptr_t rptr, input int aw);
    return rptr ^ (ptr_t'(3) << (aw - 1));
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module fifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side control of the async FIFO: write counter/address, Gray write pointer, full/almost-full/occupancy.
// Optional sticky overflow flag built only when FIFO_WR_OVERFLOW_EN is defined.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = ADDRSIZE_DEF,
  parameter int AFULL_THRESH = 12
) (
  input  logic                wCLK,
  input  logic                wRST,
  input  logic                wINC,
  input  logic [ADDRSIZE:0]   wq2_rptr,
`ifdef FIFO_WR_OVERFLOW_EN
  input  logic                wOVF_CLR,
  output logic                wOVERFLOW,
`endif
  output logic [ADDRSIZE-1:0] wADDR,
  output logic [ADDRSIZE:0]   wPTR,
  output logic                wFULL,
  output logic                wALMOST_FULL,
  output logic [ADDRSIZE:0]   wCOUNT
);

  localparam int PW = ADDRSIZE + 1;

  logic          wen;
  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rptr_full;
  logic [PW-1:0] rbin_s;
  logic [PW-1:0] count_next;
  logic          full_next;
  logic          afull_next;

  assign wen        = wINC & ~wFULL;
  assign wbin_next  = wbin + PW'(wen);
  assign wgray_next = PW'(bin2gray(ptr_t'(wbin_next)));
  assign rptr_full  = PW'(full_ptr(ptr_t'(wq2_rptr), ADDRSIZE));

  fifo_gray2bin #(.W(PW)) u_rptr_bin (
    .gray (wq2_rptr),
    .bin  (rbin_s)
  );

  // Wraps modulo 2**PW, so the extra MSB makes a full FIFO read as exactly 2**ADDRSIZE.
  assign count_next = wbin_next - rbin_s;
  assign full_next  = (wgray_next == rptr_full);
  assign afull_next = int'(count_next) >= AFULL_THRESH;

  always_ff @(posedge wCLK) begin
    if (!wRST) begin
      wbin         <= '0;
      wPTR         <= '0;
      wFULL        <= 1'b0;
      wALMOST_FULL <= 1'b0;
      wCOUNT       <= '0;
    end else begin
      wbin         <= wbin_next;
      wPTR         <= wgray_next;
      wFULL        <= full_next;
      wALMOST_FULL <= afull_next;
      wCOUNT       <= count_next;
    end
  end

  assign wADDR = wbin[ADDRSIZE-1:0];

`ifdef FIFO_WR_OVERFLOW_EN
  // A rejected write in the same cycle as a clear keeps the flag set.
  always_ff @(posedge wCLK) begin
    if (!wRST)                 wOVERFLOW <= 1'b0;
    else if (wINC && wFULL)    wOVERFLOW <= 1'b1;
    else if (wOVF_CLR)         wOVERFLOW <= 1'b0;
  end
`endif

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side control for the asynchronous FIFO. It owns the write binary counter, the write address into the dual-port memory, the Gray-coded write pointer sent to the read domain, and the full, almost-full, occupancy and overflow status. It sits directly upstream of the read-side control. It consumes the read pointer after the read pointer has passed through the two-flop synchronizer into the write domain.

## Interface
Parameters:
- ADDRSIZE, 4, memory address width; FIFO depth is 2**ADDRSIZE.
- AFULL_THRESH, 12, occupancy at or above which wALMOST_FULL asserts; legal range 1..2**ADDRSIZE.

Ports:
- wCLK  in  1  write-domain clock; all state updates on its rising edge.
- wRST  in  1  reset, synchronous, active-low.
- wINC  in  1  write request; accepted only when wFULL=0.
- wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already synchronized into wCLK.
- wOVF_CLR  in  1  clears the sticky overflow flag (present only with FIFO_WR_OVERFLOW_EN).
- wADDR  out  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0].
- wPTR  out  ADDRSIZE+1  registered Gray write pointer, to the read-domain synchronizer.
- wFULL  out  1  registered full flag.
- wALMOST_FULL  out  1  registered, wCOUNT >= AFULL_THRESH.
- wCOUNT  out  ADDRSIZE+1  registered occupancy as seen from the write domain, 0..2**ADDRSIZE.
- wOVERFLOW  out  1  sticky overflow flag (present only with FIFO_WR_OVERFLOW_EN).

## Operation
- Write enable: wen = wINC & ~wFULL. Memory write enable is driven externally with the same equation.
- Next binary count: wbin_next = wbin + wen, computed modulo 2**(ADDRSIZE+1).
- Next Gray pointer: wgray_next = (wbin_next >> 1) ^ wbin_next.
- Register updates on each wCLK edge:
  - wbin <= wbin_next.
  - wPTR <= wgray_next, so wPTR always equals gray(wbin) with no extra lag.
- Full: wFULL <= (wgray_next == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- Occupancy:
  - rbin_s = gray2bin(wq2_rptr).
  - wCOUNT <= wbin_next - rbin_s, computed modulo 2**(ADDRSIZE+1).
  - wCOUNT equals 2**ADDRSIZE exactly when wFULL=1.
- Almost full: wALMOST_FULL <= (wbin_next - rbin_s) >= AFULL_THRESH.
- Full is pessimistic. Because wq2_rptr lags the true read pointer, wFULL and wCOUNT may overstate occupancy. They never understate it.
- Wrap-around:
  - The extra MSB of wbin and wPTR distinguishes full from empty.
  - wADDR wraps from 2**ADDRSIZE-1 to 0 with no gap.
- Write while full: the request is ignored. wbin, wPTR and wADDR hold.
- Simultaneous write and read-pointer advance in the same cycle: both are folded into the next flag values. The FIFO is never reported full while it holds fewer than 2**ADDRSIZE entries as seen from the write domain.
- Reset (wRST=0 at a wCLK edge): wbin=0, wPTR=0, wADDR=0, wFULL=0, wALMOST_FULL=0, wCOUNT=0, wOVERFLOW=0.
  - Reset overrides wINC.
  - Reset asserted mid-stream discards the write pointer state. The read side must be reset in the same window.

## Timing
- A write accepted in cycle N updates wADDR, wPTR, wCOUNT, wFULL and wALMOST_FULL at the edge ending cycle N.
- A change on wq2_rptr in cycle M is reflected in wFULL, wCOUNT and wALMOST_FULL at the edge ending cycle M.
- End-to-end, a read becomes visible here 2 wCLK edges after the read pointer changes, through the external synchronizer, plus the one register stage in this block.
- wPTR changes by exactly one bit per accepted write, as required for crossing into the read domain.
- wFULL can drop in the same edge as the write that follows it is accepted. Back-to-back writes at full throughput are supported.

## Configuration
- FIFO_WR_OVERFLOW_EN, when defined:
  - wOVF_CLR and wOVERFLOW exist.
  - wOVERFLOW <= 1 on any cycle with wINC & wFULL.
  - wOVERFLOW <= 0 on wOVF_CLR.
  - If set and clear occur in the same cycle, set wins.
- FIFO_WR_OVERFLOW_EN, when undefined:
  - Neither port exists and no overflow register is built.
  - Rejected writes are silently dropped.

## Structure
- Shared package fifo_pkg holds:
  - bin2gray and gray2bin functions, parameterized on width.
  - Default ADDRSIZE.
  - The full-compare helper that inverts the two MSBs.
- The read-side control uses the same package.
- One sub-module, fifo_gray2bin (combinational, XOR prefix chain), converts wq2_rptr to binary. It is reused for read-side occupancy.

## Test plan
All scenarios use ADDRSIZE=4 and AFULL_THRESH=12.
- Reset: hold wRST=0 with wINC=1 for 3 cycles. Required: all outputs 0, and wPTR stays 0 after release.
- Fill: wq2_rptr=0 and 16 consecutive writes.
  - wADDR steps 0..15.
  - wALMOST_FULL rises after the 12th write.
  - wFULL=1 and wCOUNT=16 after the 16th write.
  - wPTR after the 16th write = 5'b11000.
- Write while full: 4 further writes at full. Required: wADDR, wPTR and wCOUNT hold. With the macro defined, wOVERFLOW=1. Then pulse wOVF_CLR together with a write (set wins) and wOVERFLOW stays 1. A second clear without a write gives wOVERFLOW=0.
- Drain release: from full, step wq2_rptr to gray(1)=5'b00001. Required: the next edge gives wFULL=0 and wCOUNT=15. A write in the same cycle keeps wFULL=1 and wCOUNT=16.
- Wrap: 40 writes with wq2_rptr tracking gray(wbin-2).
  - wCOUNT constant at 2.
  - wADDR wraps 15 to 0.
  - wPTR shows exactly one bit change per write across the 31 to 0 binary wrap.
- Randomized cross-check (directed seed): compare wFULL against wCOUNT==16 every cycle. No mismatches allowed.
